// File: rtl/arcadia_hit_pkg.sv
// Shared types for the region hit driver.
//  hit_cmd_t   : one hit command (core address, pixel-region address, hitmap)
//  drv_state_t : pulse driver FSM states
// Widths follow the ARCADIA core geometry macros; defaults apply when the
// project-wide defines are not present.

`ifndef ARCADIA_CORE_PRS
`define ARCADIA_CORE_PRS 16
`endif
`ifndef ARCADIA_PR_DATA_BITS
`define ARCADIA_PR_DATA_BITS 16
`endif
`ifndef ARCADIA_CORE_ADDRESS_BITS
`define ARCADIA_CORE_ADDRESS_BITS 4
`endif

package arcadia_hit_pkg;

  localparam int CORE_PRS          = `ARCADIA_CORE_PRS;
  localparam int PR_DATA_BITS      = `ARCADIA_PR_DATA_BITS;
  localparam int CORE_ADDRESS_BITS = `ARCADIA_CORE_ADDRESS_BITS;
  localparam int PR_ADDRESS_BITS   = $clog2(CORE_PRS);

  typedef struct packed {
    logic [CORE_ADDRESS_BITS-1:0] core_address;
    logic [PR_ADDRESS_BITS-1:0]   pr_address;
    logic [PR_DATA_BITS-1:0]      hitmap;
  } hit_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ASSERT,
    GAP
  } drv_state_t;

endpackage

// File: rtl/hit_cmd_fifo.sv
// Synchronous FIFO of hit commands.
//  clk, reset_n : clock, async active-low reset (pointers only)
//  push, push_data : write one entry (ignored when full)
//  pop,  pop_data  : read one entry (ignored when empty); pop_data shows the head
//  full, empty     : occupancy flags from extra-MSB pointer compare
//  level           : number of stored entries

module hit_cmd_fifo
  import arcadia_hit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  hit_cmd_t               push_data,
  input  logic                   pop,
  output hit_cmd_t               pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  hit_cmd_t       mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage has no reset; a slot is never read before the pointers say
  // it was written, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Pointers carry one extra wrap bit: equal -> empty, only wrap bit differs -> full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/region_hit_driver.sv
// Drives one core's region_hitmap inputs as timed pulses from queued hit commands.
//  clk, reset_n       : clock, async active-low reset
//  cfg_core_address   : address of the driven core; other cores' commands are dropped
//  cfg_pulse_len      : pulse length in cycles (0 behaves as 1), sampled at pulse start
//  hit_valid/ready    : command handshake; hit_ready = !full, no path from hit_valid
//  hit_core_address, hit_pr_address, hit_hitmap : command payload
//  region_hitmap      : registered per-region hitmaps
//  busy               : commands pending or a pulse sequence in progress
//  drop_count         : saturating count of discarded commands

module region_hit_driver
  import arcadia_hit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_BITS = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [CORE_ADDRESS_BITS-1:0]           cfg_core_address,
  input  logic [PULSE_BITS-1:0]                  cfg_pulse_len,
  input  logic                                   hit_valid,
  output logic                                   hit_ready,
  input  logic [CORE_ADDRESS_BITS-1:0]           hit_core_address,
  input  logic [PR_ADDRESS_BITS-1:0]             hit_pr_address,
  input  logic [PR_DATA_BITS-1:0]                hit_hitmap,
  output logic [CORE_PRS-1:0][PR_DATA_BITS-1:0]  region_hitmap,
  output logic                                   busy,
  output logic [7:0]                             drop_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  hit_cmd_t                              in_cmd;
  hit_cmd_t                              out_cmd;
  logic                                  push, pop, full, empty;
  logic [CNT_W-1:0]                      level;
  logic                                  ready_en, accept, keep, load_done;
  drv_state_t                            state;
  logic [CNT_W-1:0]                      pop_count;
  logic [PULSE_BITS-1:0]                 pulse_cnt;
  logic [CORE_PRS-1:0][PR_DATA_BITS-1:0] shadow;
  logic [CORE_PRS-1:0][PR_DATA_BITS-1:0] shadow_merged;
  logic                                  unused_core;

  // ready_en keeps hit_ready low while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  assign hit_ready = ready_en && !full;
  assign accept    = hit_valid && hit_ready;
  // Commands for another core, out-of-range regions or empty hitmaps are
  // acknowledged but never queued.
  assign keep      = (hit_core_address == cfg_core_address)
                  && (int'(hit_pr_address) < CORE_PRS)
                  && (hit_hitmap != '0);
  assign push      = accept && keep;

  assign in_cmd.core_address = hit_core_address;
  assign in_cmd.pr_address   = hit_pr_address;
  assign in_cmd.hitmap       = hit_hitmap;

  hit_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_cmd),
    .pop       (pop),
    .pop_data  (out_cmd),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // The core address has done its job at the filter.
  assign unused_core = ^out_cmd.core_address;

  // LOAD is only entered or held with a non-empty FIFO, so it pops every cycle.
  assign pop = (state == LOAD) && !empty;

  // LOAD ends on the FIFO_DEPTH-th pop or when this pop drains the FIFO.
  assign load_done = (pop_count == CNT_W'(FIFO_DEPTH - 1))
                  || ((level == CNT_W'(1)) && !push);

  // NOTE: default assignment first so every path drives shadow_merged and no
  // latch is inferred.
  always_comb begin
    shadow_merged = shadow;
    if (pop) shadow_merged[out_cmd.pr_address] = shadow[out_cmd.pr_address] | out_cmd.hitmap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pop_count     <= '0;
      pulse_cnt     <= '0;
      shadow        <= '0;
      region_hitmap <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state     <= LOAD;
            pop_count <= '0;
          end
        end
        LOAD: begin
          shadow    <= shadow_merged;
          pop_count <= pop_count + CNT_W'(1);
          if (load_done) begin
            // The merged map goes straight to the output so the pulse starts
            // on the first ASSERT cycle.
            state         <= ASSERT;
            region_hitmap <= shadow_merged;
            pulse_cnt     <= (cfg_pulse_len == '0) ? '0 : cfg_pulse_len - PULSE_BITS'(1);
          end
        end
        ASSERT: begin
          if (pulse_cnt == '0) begin
            state         <= GAP;
            region_hitmap <= '0;
            shadow        <= '0;
          end else begin
            pulse_cnt <= pulse_cnt - PULSE_BITS'(1);
          end
        end
        GAP: begin
          pop_count <= '0;
          state     <= empty ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           drop_count <= '0;
    else if (accept && !keep && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

  assign busy = !empty || (state != IDLE);

endmodule

// File: tb/tb_region_hit_driver.sv
// Directed testbench for region_hit_driver: reset, single pulse timing, merge,
// filtering and drop saturation, backpressure, pulse length and mid-pulse reset.

module tb_region_hit_driver;
  import arcadia_hit_pkg::*;

  typedef logic [CORE_PRS-1:0][PR_DATA_BITS-1:0] map_t;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [CORE_ADDRESS_BITS-1:0] cfg_core_address;
  logic [7:0]                   cfg_pulse_len;
  logic                         hit_valid;
  logic                         hit_ready;
  logic [CORE_ADDRESS_BITS-1:0] hit_core_address;
  logic [PR_ADDRESS_BITS-1:0]   hit_pr_address;
  logic [PR_DATA_BITS-1:0]      hit_hitmap;
  map_t                         region_hitmap;
  logic                         busy;
  logic [7:0]                   drop_count;

  int checks = 0;
  int errors = 0;

  // Pulse monitor state (written only by the monitor process).
  map_t pulse_maps[$];
  int   pulse_lens[$];
  int   cur_len  = 0;
  map_t prev_map = '0;
  int   glitches = 0;

  region_hit_driver #(.FIFO_DEPTH(4), .PULSE_BITS(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_core_address (cfg_core_address),
    .cfg_pulse_len    (cfg_pulse_len),
    .hit_valid        (hit_valid),
    .hit_ready        (hit_ready),
    .hit_core_address (hit_core_address),
    .hit_pr_address   (hit_pr_address),
    .hit_hitmap       (hit_hitmap),
    .region_hitmap    (region_hitmap),
    .busy             (busy),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  // Records every pulse (map at its first cycle, length in cycles) and counts
  // any change of a nonzero map without an intervening zero cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (region_hitmap != '0) begin
        if (prev_map == '0) begin
          pulse_maps.push_back(region_hitmap);
          cur_len = 1;
        end else begin
          if (region_hitmap != prev_map) glitches++;
          cur_len++;
        end
      end else if (prev_map != '0) begin
        pulse_lens.push_back(cur_len);
        cur_len = 0;
      end
      prev_map = region_hitmap;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns one cycle after its handshake; hit_valid
  // stays high so consecutive calls are back-to-back.
  task automatic drive(input logic [CORE_ADDRESS_BITS-1:0] core,
                       input logic [PR_ADDRESS_BITS-1:0] pr,
                       input logic [PR_DATA_BITS-1:0] map);
    int waited = 0;
    hit_valid        = 1'b1;
    hit_core_address = core;
    hit_pr_address   = pr;
    hit_hitmap       = map;
    while (!hit_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!hit_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: hit_ready=%b after %0d cycles, required 1", hit_ready, waited);
    end
    tick();
  endtask

  task automatic wait_nonzero(input int budget);
    int waited = 0;
    while (region_hitmap == '0 && waited < budget) begin
      tick();
      waited++;
    end
    if (region_hitmap == '0) begin
      checks++; errors++;
      $display("FAIL pulse_timeout: no pulse within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int waited = 0;
    while (busy && waited < budget) begin
      tick();
      waited++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic apply_reset();
    hit_valid = 1'b0;
    reset_n   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    cfg_core_address = 4'd3;
    cfg_pulse_len    = 8'd4;
    hit_valid        = 1'b0;
    hit_core_address = '0;
    hit_pr_address   = '0;
    hit_hitmap       = '0;
    repeat (2) tick();
    checks++; if (region_hitmap !== '0) begin errors++; $display("FAIL reset_map: got %h required 0", region_hitmap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", hit_ready); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
    reset_n = 1'b1;
    tick();
    checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", hit_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_reset: got %b required 0", busy); end
  endtask

  // Accept in cycle N: zero in N+1, N+2; pulse in N+3..N+6; GAP in N+7; idle in N+8.
  task automatic test_single_hit();
    map_t exp_map, want;
    int   base = pulse_maps.size();
    exp_map     = '0;
    exp_map[5]  = 16'h0081;
    cfg_pulse_len = 8'd4;
    drive(4'd3, 4'd5, 16'h0081);
    hit_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      want = (c >= 3 && c <= 6) ? exp_map : '0;
      checks++;
      if (region_hitmap !== want) begin
        errors++; $display("FAIL single_cycle_%0d: got %h required %h", c, region_hitmap, want);
      end
      if (c == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b required 1", busy); end
      end
      if (c == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b required 0", busy); end
      end
      tick();
    end
    checks++;
    if (pulse_maps.size() - base !== 1) begin
      errors++; $display("FAIL single_pulse_count: got %0d required 1", pulse_maps.size() - base);
    end
  endtask

  task automatic test_merge();
    map_t exp_map;
    int   base = pulse_maps.size();
    exp_map    = '0;
    exp_map[2] = 16'h00FF;
    exp_map[7] = 16'h8000;
    cfg_pulse_len = 8'd2;
    drive(4'd3, 4'd2, 16'h000F);
    drive(4'd3, 4'd2, 16'h00F0);
    drive(4'd3, 4'd7, 16'h8000);
    hit_valid = 1'b0;
    wait_idle(50);
    checks++;
    if (pulse_maps.size() - base !== 1 || pulse_lens.size() < base + 1) begin
      errors++; $display("FAIL merge_pulse_count: got %0d required 1", pulse_maps.size() - base);
    end else begin
      checks++; if (pulse_maps[base] !== exp_map) begin errors++; $display("FAIL merge_map: got %h required %h", pulse_maps[base], exp_map); end
      checks++; if (pulse_lens[base] !== 2) begin errors++; $display("FAIL merge_len: got %0d required 2", pulse_lens[base]); end
    end
  endtask

  // pr_address cannot encode CORE_PRS with $clog2(CORE_PRS) bits, so the third
  // discarded command is a second foreign-core command.
  task automatic test_filter();
    int base;
    apply_reset();
    base = pulse_maps.size();
    drive(4'd9, 4'd3, 16'hFFFF);
    drive(4'd3, 4'd4, 16'h0000);
    drive(4'd0, 4'd1, 16'h0001);
    hit_valid = 1'b0;
    repeat (10) tick();
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL filter_drop3: got %0d required 3", drop_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL filter_busy: got %b required 0", busy); end
    checks++; if (region_hitmap !== '0) begin errors++; $display("FAIL filter_map: got %h required 0", region_hitmap); end
    checks++; if (pulse_maps.size() !== base) begin errors++; $display("FAIL filter_no_pulse: got %0d pulses required 0", pulse_maps.size() - base); end
    for (int i = 0; i < 251; i++) drive(4'd9, 4'd0, 16'h0001);
    hit_valid = 1'b0;
    checks++; if (drop_count !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d required 254", drop_count); end
    drive(4'd9, 4'd0, 16'h0001);
    hit_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d required 255", drop_count); end
    for (int i = 0; i < 45; i++) drive(4'd9, 4'd0, 16'h0001);
    hit_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d required 255", drop_count); end
  endtask

  // One command starts a 20-cycle pulse; five more arrive with hit_valid held.
  // Four fill the FIFO, the fifth waits. Expected pulses: {0}, {1..4}, {5}.
  task automatic test_backpressure();
    map_t exp_maps[3];
    int   base;
    apply_reset();
    exp_maps[0] = '0; exp_maps[0][0] = 16'h0001;
    exp_maps[1] = '0;
    for (int i = 1; i <= 4; i++) exp_maps[1][i] = 16'h0001 << i;
    exp_maps[2] = '0; exp_maps[2][5] = 16'h0020;
    cfg_pulse_len = 8'd20;
    base = pulse_maps.size();
    drive(4'd3, 4'd0, 16'h0001);
    hit_valid = 1'b0;
    wait_nonzero(20);
    for (int i = 1; i <= 4; i++) drive(4'd3, 4'(i), 16'h0001 << i);
    checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b required 0", hit_ready); end
    drive(4'd3, 4'd5, 16'h0020);
    hit_valid = 1'b0;
    wait_idle(300);
    checks++;
    if (pulse_maps.size() - base !== 3 || pulse_lens.size() < base + 3) begin
      errors++; $display("FAIL bp_pulse_count: got %0d required 3", pulse_maps.size() - base);
    end else begin
      for (int p = 0; p < 3; p++) begin
        checks++; if (pulse_maps[base+p] !== exp_maps[p]) begin errors++; $display("FAIL bp_map_%0d: got %h required %h", p, pulse_maps[base+p], exp_maps[p]); end
        checks++; if (pulse_lens[base+p] !== 20) begin errors++; $display("FAIL bp_len_%0d: got %0d required 20", p, pulse_lens[base+p]); end
      end
    end
  endtask

  task automatic test_pulse_len();
    map_t exp_map;
    int   base = pulse_maps.size();
    exp_map    = '0;
    exp_map[9] = 16'h1234;
    cfg_pulse_len = 8'd0;
    drive(4'd3, 4'd9, 16'h1234);
    hit_valid = 1'b0;
    wait_idle(30);
    checks++;
    if (pulse_maps.size() - base !== 1 || pulse_lens.size() < base + 1) begin
      errors++; $display("FAIL len0_count: got %0d required 1", pulse_maps.size() - base);
    end else begin
      checks++; if (pulse_maps[base] !== exp_map) begin errors++; $display("FAIL len0_map: got %h required %h", pulse_maps[base], exp_map); end
      checks++; if (pulse_lens[base] !== 1) begin errors++; $display("FAIL len0_len: got %0d required 1", pulse_lens[base]); end
    end
    base = pulse_maps.size();
    cfg_pulse_len = 8'd6;
    drive(4'd3, 4'd1, 16'h00AA);
    hit_valid = 1'b0;
    wait_nonzero(10);
    tick();
    cfg_pulse_len = 8'd1;
    tick();
    cfg_pulse_len = 8'd40;
    wait_idle(60);
    checks++;
    if (pulse_lens.size() - base !== 1) begin
      errors++; $display("FAIL len_change_count: got %0d required 1", pulse_lens.size() - base);
    end else begin
      checks++; if (pulse_lens[base] !== 6) begin errors++; $display("FAIL len_change_len: got %0d required 6", pulse_lens[base]); end
    end
  endtask

  task automatic test_reset_mid_assert();
    int base;
    cfg_pulse_len = 8'd10;
    drive(4'd9, 4'd0, 16'h0001);
    drive(4'd3, 4'd1, 16'h0001);
    hit_valid = 1'b0;
    wait_nonzero(10);
    drive(4'd3, 4'd2, 16'h0002);
    drive(4'd3, 4'd3, 16'h0004);
    hit_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (region_hitmap !== '0) begin errors++; $display("FAIL mid_reset_map: got %h required 0", region_hitmap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
    checks++; if (hit_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b required 0", hit_ready); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_reset_drop: got %0d required 0", drop_count); end
    #20;
    reset_n = 1'b1;
    base = pulse_maps.size();
    repeat (30) tick();
    checks++; if (pulse_maps.size() !== base) begin errors++; $display("FAIL post_reset_pulse: got %0d pulses required 0", pulse_maps.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", hit_ready); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_merge();
    test_filter();
    test_backpressure();
    test_pulse_len();
    test_reset_mid_assert();
    checks++;
    if (glitches !== 0) begin
      errors++; $display("FAIL pulse_modified: got %0d in-pulse changes required 0", glitches);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
